dsa_fetch_ctrl: RTL and testbench

DSA_FETCH_CTRL -- requirements
Module: dsa_fetch_ctrl

---
 rtl/dsa_fetch_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_dsa_fetch_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsa_fetch_ctrl.sv
// rtl/dsa_fetch_ctrl.sv - bilinear scaler fetch/issue/writeback sequencer
// Walks destination pixels in raster order, fetches a 2x2 source quad and hands it to the datapath.
module dsa_fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    input  logic [9:0]  src_w,
    input  logic [9:0]  src_h,
    input  logic [9:0]  dst_w,
    input  logic [9:0]  dst_h,
    input  logic [15:0] scale_x,
    input  logic [15:0] scale_y,
    output logic        src_rd,
    output logic [19:0] src_addr,
    input  logic [7:0]  src_data,
    output logic        dp_start,
    output logic [7:0]  p00,
    output logic [7:0]  p01,
    output logic [7:0]  p10,
    output logic [7:0]  p11,
    output logic [15:0] a,
    output logic [15:0] b,
    input  logic        dp_done,
    input  logic [7:0]  dp_pixel,
    output logic        dst_wr,
    output logic [19:0] dst_addr,
    output logic [7:0]  dst_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_RD, S_RDLAST, S_ISSUE, S_WAIT, S_WRITE, S_FIN
    } state_t;

    state_t      state, state_n;

    logic [9:0]  c_src_w, c_src_h, c_dst_w, c_dst_h;
    logic [15:0] c_scale_x, c_scale_y;
    logic [17:0] sx, sy;
    logic [9:0]  ox, oy;
    logic [9:0]  x0, x1, y0, y1;
    logic [1:0]  rd_cnt;

    logic [9:0]  sx_int, sy_int, src_w_m1, src_h_m1;
    logic [9:0]  x0_n, x1_n, y0_n, y1_n;
    logic [9:0]  rd_x, rd_y;
    logic        row_end, last_pix;
    logic        cap_en;
    logic [1:0]  cap_idx;

    assign row_end  = (ox == c_dst_w - 10'd1);
    assign last_pix = row_end && (oy == c_dst_h - 10'd1);

    // Clamp the integer sample position and its right/lower neighbour to the source edge.
    always_comb begin
        sx_int   = sx[17:8];
        sy_int   = sy[17:8];
        src_w_m1 = c_src_w - 10'd1;
        src_h_m1 = c_src_h - 10'd1;
        x0_n     = (sx_int > src_w_m1) ? src_w_m1 : sx_int;
        y0_n     = (sy_int > src_h_m1) ? src_h_m1 : sy_int;
        if (({1'b0, x0_n} + 11'd1) > {1'b0, src_w_m1})
            x1_n = src_w_m1;
        else
            x1_n = x0_n + 10'd1;
        if (({1'b0, y0_n} + 11'd1) > {1'b0, src_h_m1})
            y1_n = src_h_m1;
        else
            y1_n = y0_n + 10'd1;
    end

    // Read k of the quad: bit 0 selects the right column, bit 1 the lower row.
    assign rd_x = rd_cnt[0] ? x1 : x0;
    assign rd_y = rd_cnt[1] ? y1 : y0;

    // Data returns one cycle after each read, so capture lags the read counter by one.
    assign cap_en  = ((state == S_RD) && (rd_cnt != 2'd0)) || (state == S_RDLAST);
    assign cap_idx = (state == S_RDLAST) ? 2'd3 : (rd_cnt - 2'd1);

    always_comb begin
        state_n  = state;
        src_rd   = 1'b0;
        dp_start = 1'b0;
        dst_wr   = 1'b0;
        src_addr = 20'd0;
        dst_addr = 20'd0;
        busy     = (state != S_IDLE);
        done     = (state == S_FIN);
        case (state)
            S_IDLE: begin
                if (cfg_start)
                    state_n = (dst_w == 10'd0 || dst_h == 10'd0) ? S_FIN : S_CALC;
            end
            S_CALC: state_n = S_RD;
            S_RD: begin
                src_rd   = 1'b1;
                src_addr = ({10'd0, rd_y} * {10'd0, c_src_w}) + {10'd0, rd_x};
                if (rd_cnt == 2'd3)
                    state_n = S_RDLAST;
            end
            S_RDLAST: state_n = S_ISSUE;
            S_ISSUE: begin
                dp_start = 1'b1;
                state_n  = S_WAIT;
            end
            S_WAIT: begin
                if (dp_done)
                    state_n = S_WRITE;
            end
            S_WRITE: begin
                dst_wr   = 1'b1;
                dst_addr = ({10'd0, oy} * {10'd0, c_dst_w}) + {10'd0, ox};
                state_n  = last_pix ? S_FIN : S_CALC;
            end
            S_FIN: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_src_w   <= 10'd0;
            c_src_h   <= 10'd0;
            c_dst_w   <= 10'd0;
            c_dst_h   <= 10'd0;
            c_scale_x <= 16'd0;
            c_scale_y <= 16'd0;
            sx        <= 18'd0;
            sy        <= 18'd0;
            ox        <= 10'd0;
            oy        <= 10'd0;
            x0        <= 10'd0;
            x1        <= 10'd0;
            y0        <= 10'd0;
            y1        <= 10'd0;
            rd_cnt    <= 2'd0;
            a         <= 16'd0;
            b         <= 16'd0;
            dst_data  <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        c_src_w   <= src_w;
                        c_src_h   <= src_h;
                        c_dst_w   <= dst_w;
                        c_dst_h   <= dst_h;
                        c_scale_x <= scale_x;
                        c_scale_y <= scale_y;
                        sx        <= 18'd0;
                        sy        <= 18'd0;
                        ox        <= 10'd0;
                        oy        <= 10'd0;
                    end
                end
                S_CALC: begin
                    x0     <= x0_n;
                    x1     <= x1_n;
                    y0     <= y0_n;
                    y1     <= y1_n;
                    a      <= {8'h00, sx[7:0]};
                    b      <= {8'h00, sy[7:0]};
                    rd_cnt <= 2'd0;
                end
                S_RD: rd_cnt <= rd_cnt + 2'd1;
                S_WAIT: begin
                    if (dp_done)
                        dst_data <= dp_pixel;
                end
                S_WRITE: begin
                    if (row_end) begin
                        ox <= 10'd0;
                        oy <= oy + 10'd1;
                        sx <= 18'd0;
                        sy <= sy + {2'b00, c_scale_y};
                    end else begin
                        ox <= ox + 10'd1;
                        sx <= sx + {2'b00, c_scale_x};
                    end
                end
                default: ;
            endcase
        end
    end

    // Quad capture order: p00 (x0,y0), p10 (x1,y0), p01 (x0,y1), p11 (x1,y1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p00 <= 8'd0;
            p10 <= 8'd0;
            p01 <= 8'd0;
            p11 <= 8'd0;
        end else if (cap_en) begin
            case (cap_idx)
                2'd0:    p00 <= src_data;
                2'd1:    p10 <= src_data;
                2'd2:    p01 <= src_data;
                default: p11 <= src_data;
            endcase
        end
    end

endmodule

// File: tb/tb_dsa_fetch_ctrl.sv
// tb/tb_dsa_fetch_ctrl.sv - directed self-checking bench for dsa_fetch_ctrl
module tb_dsa_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [9:0]  src_w = '0, src_h = '0, dst_w = '0, dst_h = '0;
    logic [15:0] scale_x = '0, scale_y = '0;
    logic        src_rd;
    logic [19:0] src_addr;
    logic [7:0]  src_data = '0;
    logic        dp_start;
    logic [7:0]  p00, p01, p10, p11;
    logic [15:0] a, b;
    logic        dp_done = 1'b0;
    logic [7:0]  dp_pixel = '0;
    logic        dst_wr;
    logic [19:0] dst_addr;
    logic [7:0]  dst_data;
    logic        busy, done;

    dsa_fetch_ctrl dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
        .scale_x(scale_x), .scale_y(scale_y),
        .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
        .dp_start(dp_start), .p00(p00), .p01(p01), .p10(p10), .p11(p11),
        .a(a), .b(b), .dp_done(dp_done), .dp_pixel(dp_pixel),
        .dst_wr(dst_wr), .dst_addr(dst_addr), .dst_data(dst_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Source memory with one-cycle read latency.
    logic [7:0] mem [0:63];
    always @(posedge clk) begin
        if (src_rd) src_data <= mem[src_addr[5:0]];
    end

    // Reference bilinear datapath with programmable response delay (1 = cycle after dp_start).
    int dp_delay = 1;
    int dp_cnt = 0;
    logic [7:0] dp_pend = '0;
    function automatic logic [7:0] bilerp(input int q00, q10, q01, q11, wa, wb);
        int top, bot;
        top = q00 * (256 - wa) + q10 * wa;
        bot = q01 * (256 - wa) + q11 * wa;
        return 8'((top * (256 - wb) + bot * wb) >> 16);
    endfunction
    always @(posedge clk) begin
        dp_done <= 1'b0;
        if (rst) begin
            dp_cnt <= 0;
        end else if (dp_start) begin
            dp_pend <= bilerp(p00, p10, p01, p11, int'(a[8:0]), int'(b[8:0]));
            if (dp_delay <= 1) begin
                dp_done  <= 1'b1;
                dp_pixel <= bilerp(p00, p10, p01, p11, int'(a[8:0]), int'(b[8:0]));
                dp_cnt   <= 0;
            end else begin
                dp_cnt <= dp_delay - 1;
            end
        end else if (dp_cnt > 0) begin
            dp_cnt <= dp_cnt - 1;
            if (dp_cnt == 1) begin
                dp_done  <= 1'b1;
                dp_pixel <= dp_pend;
            end
        end
    end

    // Observation queues, sampled on the falling edge.
    logic [19:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [19:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          wr_cyc_q[$];
    int          ds_cyc_q[$];
    logic [15:0] a_q[$];
    logic [63:0] snap = '0;
    bit          in_wait = 0;
    int          stab_err = 0;

    always @(negedge clk) begin
        if (src_rd) begin rd_addr_q.push_back(src_addr); rd_cyc_q.push_back(cyc); end
        if (dst_wr) begin
            wr_addr_q.push_back(dst_addr); wr_data_q.push_back(dst_data); wr_cyc_q.push_back(cyc);
        end
        if (dp_start) begin
            ds_cyc_q.push_back(cyc);
            a_q.push_back(a);
            snap = {p00, p01, p10, p11, a, b};
            in_wait = 1;
        end else if (in_wait) begin
            if (dst_wr) in_wait = 0;
            else if ({p00, p01, p10, p11, a, b} !== snap) stab_err++;
        end
    end

    int t0 = 0;

    task automatic clear_obs;
        rd_addr_q.delete(); rd_cyc_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        ds_cyc_q.delete(); a_q.delete();
        stab_err = 0; in_wait = 0;
    endtask

    task automatic start_frame(input int sw, sh, dw, dh, sxs, sys);
        @(negedge clk);
        clear_obs();
        src_w = 10'(sw); src_h = 10'(sh); dst_w = 10'(dw); dst_h = 10'(dh);
        scale_x = 16'(sxs); scale_y = 16'(sys);
        cfg_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc, output bit to);
        int n = 0;
        while (!done && n < budget) begin @(negedge clk); n++; end
        to = !done;
        dcyc = cyc - t0;
    endtask

    task automatic load_identity;
        for (int i = 0; i < 64; i++) mem[i] = 8'(50 + i);
        mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, src_rd, dp_start, dst_wr} !== 5'b0) begin
            failures++; $display("FAIL reset_strobes: got %b expected 00000", {busy, done, src_rd, dp_start, dst_wr});
        end
        checks++;
        if ({src_addr, dst_addr, dst_data, p00, p01, p10, p11, a, b} !== '0) begin
            failures++; $display("FAIL reset_data: got %h expected 0", {src_addr, dst_addr, dst_data, p00, p01, p10, p11, a, b});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity;
        int dc; bit to;
        int exp_d[4] = '{10, 20, 30, 40};
        load_identity();
        dp_delay = 1;
        start_frame(2, 2, 2, 2, 'h100, 'h100);
        wait_done(200, dc, to);
        checks++;
        if (to || dc != 37) begin
            failures++; $display("FAIL identity_done_cycle: got %0d (timeout %0d) expected 37", dc, to);
        end
        checks++;
        if (wr_addr_q.size() != 4) begin
            failures++; $display("FAIL identity_write_count: got %0d expected 4", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr_q[i] !== 20'(i) || wr_data_q[i] !== 8'(exp_d[i])) begin
                    failures++; $display("FAIL identity_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                                         i, wr_addr_q[i], wr_data_q[i], i, exp_d[i]);
                end
            end
        end
        foreach (a_q[i]) begin
            checks++;
            if (a_q[i] !== 16'h0000) begin
                failures++; $display("FAIL identity_a%0d: got %h expected 0000", i, a_q[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL identity_idle: got busy %b done %b expected 0 0", busy, done);
        end
    endtask

    task automatic test_read_order;
        int dc; bit to;
        load_identity();
        start_frame(4, 4, 1, 1, 'h180, 'h180);
        wait_done(100, dc, to);
        checks++;
        if (to || rd_addr_q.size() != 4) begin
            failures++; $display("FAIL read_order_count: got %0d reads (timeout %0d) expected 4", rd_addr_q.size(), to);
        end else begin
            checks++;
            if (rd_addr_q[0] !== 20'd0 || rd_addr_q[1] !== 20'd1 || rd_addr_q[2] !== 20'd4 || rd_addr_q[3] !== 20'd5) begin
                failures++; $display("FAIL read_order_addr: got %0d,%0d,%0d,%0d expected 0,1,4,5",
                                     rd_addr_q[0], rd_addr_q[1], rd_addr_q[2], rd_addr_q[3]);
            end
            checks++;
            if (rd_cyc_q[3] - rd_cyc_q[0] != 3) begin
                failures++; $display("FAIL read_order_consecutive: got span %0d expected 3", rd_cyc_q[3] - rd_cyc_q[0]);
            end
        end
        checks++;
        if (wr_data_q.size() != 1 || wr_data_q[0] !== 8'd10) begin
            failures++; $display("FAIL read_order_pixel: got %0d writes first %0d expected 1 write of 10",
                                 wr_data_q.size(), wr_data_q.size() > 0 ? int'(wr_data_q[0]) : -1);
        end
    endtask

    task automatic test_upscale;
        int dc; bit to;
        int exp_d[4] = '{0, 50, 100, 100};
        int exp_a[4] = '{0, 'h80, 0, 'h80};
        int exp_x0[4] = '{0, 0, 1, 1};
        mem[0] = 8'd0; mem[1] = 8'd100;
        start_frame(2, 1, 4, 1, 'h80, 'h100);
        wait_done(200, dc, to);
        checks++;
        if (to || wr_data_q.size() != 4 || a_q.size() != 4 || rd_addr_q.size() != 16) begin
            failures++; $display("FAIL upscale_counts: got writes %0d issues %0d reads %0d (timeout %0d) expected 4 4 16",
                                 wr_data_q.size(), a_q.size(), rd_addr_q.size(), to);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr_q[i] !== 20'(i) || wr_data_q[i] !== 8'(exp_d[i]) || a_q[i] !== 16'(exp_a[i]) ||
                    rd_addr_q[4*i] !== 20'(exp_x0[i]) || rd_addr_q[4*i+1] !== 20'd1) begin
                    failures++; $display("FAIL upscale_px%0d: got addr %0d data %0d a %h x0 %0d x1 %0d expected addr %0d data %0d a %h x0 %0d x1 1",
                                         i, wr_addr_q[i], wr_data_q[i], a_q[i], rd_addr_q[4*i], rd_addr_q[4*i+1],
                                         i, exp_d[i], exp_a[i], exp_x0[i]);
                end
            end
        end
    endtask

    task automatic test_zero_size;
        int dc; bit to;
        start_frame(2, 2, 0, 2, 'h100, 'h100);
        wait_done(10, dc, to);
        checks++;
        if (to || dc != 1) begin
            failures++; $display("FAIL zero_done_cycle: got %0d (timeout %0d) expected 1", dc, to);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rd_addr_q.size() != 0 || wr_addr_q.size() != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL zero_activity: got reads %0d writes %0d busy %b expected 0 0 0",
                                 rd_addr_q.size(), wr_addr_q.size(), busy);
        end
    endtask

    task automatic test_stall;
        int dc; bit to;
        load_identity();
        dp_delay = 6;
        start_frame(2, 2, 1, 1, 'h100, 'h100);
        wait_done(100, dc, to);
        dp_delay = 1;
        checks++;
        if (to || wr_cyc_q.size() != 1 || ds_cyc_q.size() != 1) begin
            failures++; $display("FAIL stall_counts: got writes %0d issues %0d (timeout %0d) expected 1 1",
                                 wr_cyc_q.size(), ds_cyc_q.size(), to);
        end else begin
            checks++;
            if (wr_cyc_q[0] - ds_cyc_q[0] != 7) begin
                failures++; $display("FAIL stall_write_delay: got %0d expected 7", wr_cyc_q[0] - ds_cyc_q[0]);
            end
            checks++;
            if (wr_data_q[0] !== 8'd10) begin
                failures++; $display("FAIL stall_pixel: got %0d expected 10", wr_data_q[0]);
            end
        end
        checks++;
        if (stab_err != 0) begin
            failures++; $display("FAIL stall_operand_stable: got %0d changes expected 0", stab_err);
        end
    endtask

    task automatic test_ignore_start;
        int dc; bit to;
        load_identity();
        start_frame(2, 2, 2, 2, 'h100, 'h100);
        repeat (3) @(negedge clk);
        dst_w = 10'd1; dst_h = 10'd1; src_w = 10'd4;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_done(200, dc, to);
        checks++;
        if (to || dc != 37 || wr_data_q.size() != 4) begin
            failures++; $display("FAIL ignore_restart: got done %0d writes %0d (timeout %0d) expected 37 4",
                                 dc, wr_data_q.size(), to);
        end else begin
            checks++;
            if (wr_data_q[3] !== 8'd40 || wr_addr_q[3] !== 20'd3) begin
                failures++; $display("FAIL ignore_last_write: got addr %0d data %0d expected 3 40", wr_addr_q[3], wr_data_q[3]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int dc; bit to;
        load_identity();
        start_frame(2, 2, 2, 2, 'h100, 'h100);
        while (!src_rd && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!src_rd) begin
            failures++; $display("FAIL reset_mid_reach_rd: got src_rd %b expected 1", src_rd);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, src_rd, dp_start, dst_wr} !== 5'b0 ||
            {src_addr, dst_addr, dst_data, p00, p01, p10, p11, a, b} !== '0) begin
            failures++; $display("FAIL reset_mid_outputs: got strobes %b data %h expected 0",
                                 {busy, done, src_rd, dp_start, dst_wr}, {src_addr, dst_addr, dst_data, p00, p01, p10, p11, a, b});
        end
        clear_obs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (rd_addr_q.size() != 0 || wr_addr_q.size() != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_abort: got reads %0d writes %0d busy %b expected 0 0 0",
                                 rd_addr_q.size(), wr_addr_q.size(), busy);
        end
        start_frame(2, 2, 1, 1, 'h100, 'h100);
        wait_done(100, dc, to);
        checks++;
        if (to || wr_data_q.size() != 1 || wr_data_q[0] !== 8'd10) begin
            failures++; $display("FAIL reset_mid_recover: got writes %0d (timeout %0d) expected one write of 10",
                                 wr_data_q.size(), to);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_read_order();
        test_upscale();
        test_zero_size();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
